uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Asynchronous serial receiver for 8N1-style UART frames: idle-high line, one start bit (0), FRAME_WIDTH data bits sent LSB first, and one stop bit (1). It oversamples the `rx` line with the system clock and samples each bit at its centre. It delivers the received word in parallel with `done`, `busy` and `err` status flags. It sits between the external RX pin and the host logic that consumes bytes.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits/s.
- FRAME_WIDTH, 8: number of data bits per frame.
- Derived, not overridable: BIT_PERIOD = CLK_FREQ / BAUD_RATE, integer division; 10416 clocks at the defaults.
- Derived, not overridable: HALF_PERIOD = BIT_PERIOD / 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_en  input  1  receiver enable; high = receiving allowed.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  FRAME_WIDTH  last correctly framed word; bit 0 is the first data bit received.
- done  output  1  a frame with a valid stop bit has been received.
- busy  output  1  a frame is in progress.
- err  output  1  framing error: stop bit sampled as 0.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; data = 0, done = 0, busy = 0, err = 0; counters and the synchronizer are cleared (synchronizer to 1, idle level).
- Input synchronization: `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Bit timer: counts 0..BIT_PERIOD-1. Its width is sized by clog2(BIT_PERIOD).
- IDLE:
  - busy = 0.
  - When rx_en = 1 and synchronized rx = 0 (start edge): clear done and err, set busy = 1, go to START, reset the timer.
  - While rx_en = 0, the start edge is ignored.
- START:
  - After HALF_PERIOD clocks, re-sample the line.
  - If 0: go to DATA, reset the timer and the bit index.
  - If 1: treat as a glitch; return to IDLE with busy = 0 and done/err left at 0.
- DATA:
  - Every BIT_PERIOD clocks (i.e. at bit centres), shift the sample into a shift register, LSB first. The sample for index i lands in bit i.
  - After FRAME_WIDTH samples, go to STOP.
- STOP:
  - After BIT_PERIOD clocks, at the stop-bit centre, sample the line.
  - If 1: data <= shift register, done = 1, err = 0.
  - If 0: err = 1, done = 0, data unchanged.
  - In both cases busy = 0 and the state returns to IDLE on the same clock.
  - Returning at mid-stop bit lets the receiver catch a start bit that immediately follows.
- Flag lifetime:
  - done and err are levels, held until the next accepted start edge or reset.
  - done and err are never 1 simultaneously.
- Latency: done/err assert about (FRAME_WIDTH + 1.5) × BIT_PERIOD + 3 clocks after the falling start edge on `rx`, i.e. ≈ 9.5 bit times at the defaults.
- rx_en deasserted mid-frame: abort to IDLE on the next clock; busy = 0; data, done and err unchanged.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- The line must return high before a new start edge is recognized. A line held low after a framing error is not re-detected as a start until it has been seen high for at least one clock.

Test Plan:
1. Reset low 100 ns, then rst high and rx_en = 1. Send start 0, data 8'b0110_1100 (LSB first), stop 1, at 104160 ns per bit. Then wait 1 frame + 1 µs. Required: data = 8'b0110_1100, done = 1, err = 0, busy = 0. busy must be 1 throughout the frame.
2. Follow with the frame 8'b1010_1111 and a valid stop bit. Required: data = 8'b1010_1111, done = 1, err = 0, busy = 0. done must have dropped to 0 at that frame's start edge.
3. Send 8'b1010_1111 with stop = 0. Required: err = 1, done = 0, busy = 0, data keeps its previous value. Then drive the line high and send a good frame 8'h5A: err clears, done = 1, data = 8'h5A.
4. Drive a low glitch of 0.25 bit time on idle rx. Required: busy pulses, returns to 0 after ~HALF_PERIOD, and done/err/data are unchanged apart from flags cleared at the edge.
5. Hold rx_en = 0 and send a full frame. Required: busy stays 0 and data/done are unchanged. Next, set rx_en = 1 and deassert it mid-frame: busy returns to 0 and there is no done/err.
6. Pull rst low at data bit 4 of a frame. Required: data = 0, done = busy = err = 0 immediately. A following complete frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: the receiver's line and host-facing signals in one bundle.
//   rx_en : receiver enable (host -> receiver)
//   rx    : serial line, idle high (pin -> receiver)
//   data  : last correctly framed word, bit 0 = first data bit received
//   done  : level, a frame with a valid stop bit was received
//   busy  : level, a frame is in progress
//   err   : level, the last frame had a stop bit sampled as 0
// master = the side that drives the line and consumes words (host / bench),
// slave  = the receiver itself.
interface uart_rx_if #(
  parameter int FRAME_WIDTH = 8
);
  logic                   rx_en;
  logic                   rx;
  logic [FRAME_WIDTH-1:0] data;
  logic                   done;
  logic                   busy;
  logic                   err;

  modport master (
    output rx_en, rx,
    input  data, done, busy, err
  );

  modport slave (
    input  rx_en, rx,
    output data, done, busy, err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling receiver for idle-high, start(0) / FRAME_WIDTH data
// bits LSB first / stop(1) serial frames. The line is sampled at bit centres
// derived from a bit timer running on the system clock.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : uart_rx_if.slave -- rx_en, rx in; data, done, busy, err out
module uart_rx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int FRAME_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDX_W       = $clog2(FRAME_WIDTH + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_s1_q, rx_s1_d;
  logic                   rx_s2_q, rx_s2_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] shreg_q, shreg_d;
  logic [FRAME_WIDTH-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  // A start is a falling edge of the synchronized line, not a low level, so a
  // line stuck low after a framing error must first be seen high.
  logic start_edge;
  assign start_edge = bus.rx_en && !rx_s2_q && rx_prev_q;

  always_comb begin
    rx_s1_d   = bus.rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    state_d   = state_q;
    timer_d   = timer_q + CNT_W'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    done_d    = done_q;
    busy_d    = busy_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        timer_d = '0;
        if (start_edge) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (!rx_s2_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          // Right shift with the new sample entering at the MSB: after
          // FRAME_WIDTH samples the first bit received sits in bit 0.
          shreg_d = shreg_q >> 1;
          shreg_d[FRAME_WIDTH-1] = rx_s2_q;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          timer_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (rx_s2_q) begin
            data_d = shreg_q;
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            done_d = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase

    // Disabling mid-frame drops the frame without touching the result flags.
    if (state_q != IDLE && !bus.rx_en) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      timer_d = '0;
      data_d  = data_q;
      done_d  = done_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      timer_q   <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.data = data_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx. Runs the receiver at 16 clocks per bit so
// every scenario fits in a short run; frames are driven on rx and expected
// results are queued at send time and popped once the receiver goes idle.
module tb_uart_rx;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 6_250_000;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int BIT_NS    = BIT_CLKS * 10;

  typedef struct packed {
    logic [7:0] data;
    logic       done;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  uart_rx_if #(.FRAME_WIDTH(8)) bus ();

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FRAME_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         total = 0;
  int         bad   = 0;
  exp_t       sb_q[$];
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one frame; the line is left at the stop-bit level. busy is checked
  // at the centre of the start and data bits against exp_busy, and when the
  // frame is expected to be accepted the flags must already be clear.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic exp_busy, input string tag);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      #(BIT_NS / 2);
      if (i < 9) begin
        total++;
        if (bus.busy !== exp_busy) begin
          bad++;
          $display("FAIL %s busy bit%0d: got %b want %b", tag, i, bus.busy, exp_busy);
        end
      end
      if (i == 0 && exp_busy) begin
        total++;
        if ({bus.done, bus.err} !== 2'b00) begin
          bad++;
          $display("FAIL %s flags at start edge: done/err got %b%b want 00", tag, bus.done, bus.err);
        end
      end
      #(BIT_NS / 2);
    end
  endtask

  // Bounded wait for the receiver to finish, then pop the matching expectation.
  task automatic get_result(output exp_t e, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * BIT_CLKS; i++) begin
      if (!bus.busy && (bus.done || bus.err)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin
      e  = '0;
      ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.rx = 1'b1; bus.rx_en = 1'b0;
    #50;
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset data: got %h want 00", bus.data); end
    total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    total++; if (bus.err !== 1'b0)   begin bad++; $display("FAIL reset err: got %b want 0", bus.err); end
    #50;
    rst = 1'b1; bus.rx_en = 1'b1;
    #(BIT_NS);
  endtask

  task automatic test_good_frames();
    exp_t e; logic ok;
    logic [7:0] words [2];
    words[0] = 8'b0110_1100;
    words[1] = 8'b1010_1111;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{data: words[k], done: 1'b1, err: 1'b0});
      send_frame(words[k], 1'b1, 1'b1, "good");
      get_result(e, ok);
      total++; if (!ok) begin bad++; $display("FAIL good%0d timeout: busy=%b done=%b err=%b", k, bus.busy, bus.done, bus.err); end
      total++;
      if ({bus.data, bus.done, bus.err, bus.busy} !== {e.data, e.done, e.err, 1'b0}) begin
        bad++;
        $display("FAIL good%0d result: got data=%h done=%b err=%b busy=%b want data=%h done=%b err=%b busy=0",
                 k, bus.data, bus.done, bus.err, bus.busy, e.data, e.done, e.err);
      end
      last_good = words[k];
    end
  endtask

  task automatic test_framing_error();
    exp_t e; logic ok;
    sb_q.push_back('{data: last_good, done: 1'b0, err: 1'b1});
    send_frame(8'b1010_1111, 1'b0, 1'b1, "ferr");
    get_result(e, ok);
    total++; if (!ok) begin bad++; $display("FAIL ferr timeout: busy=%b err=%b", bus.busy, bus.err); end
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {e.data, e.done, e.err, 1'b0}) begin
      bad++;
      $display("FAIL ferr result: got data=%h done=%b err=%b busy=%b want data=%h done=%b err=%b busy=0",
               bus.data, bus.done, bus.err, bus.busy, e.data, e.done, e.err);
    end
    // Line held low after the error must not start a new frame.
    #(2 * BIT_NS);
    total++;
    if ({bus.busy, bus.err} !== 2'b01) begin
      bad++;
      $display("FAIL ferr held low: got busy=%b err=%b want busy=0 err=1", bus.busy, bus.err);
    end
    bus.rx = 1'b1;
    #(BIT_NS);
    sb_q.push_back('{data: 8'h5A, done: 1'b1, err: 1'b0});
    send_frame(8'h5A, 1'b1, 1'b1, "recover");
    get_result(e, ok);
    total++; if (!ok) begin bad++; $display("FAIL recover timeout: busy=%b done=%b", bus.busy, bus.done); end
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {e.data, e.done, e.err, 1'b0}) begin
      bad++;
      $display("FAIL recover result: got data=%h done=%b err=%b busy=%b want data=%h done=%b err=%b busy=0",
               bus.data, bus.done, bus.err, bus.busy, e.data, e.done, e.err);
    end
    last_good = 8'h5A;
  endtask

  task automatic test_glitch();
    bus.rx = 1'b0;
    #(BIT_NS / 4);
    bus.rx = 1'b1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL glitch busy pulse: got %b want 1", bus.busy); end
    #(BIT_NS * 3 / 4);
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {last_good, 3'b000}) begin
      bad++;
      $display("FAIL glitch after: got data=%h done=%b err=%b busy=%b want data=%h done=0 err=0 busy=0",
               bus.data, bus.done, bus.err, bus.busy, last_good);
    end
    #(BIT_NS);
  endtask

  task automatic test_enable();
    exp_t e; logic ok;
    sb_q.push_back('{data: 8'h3C, done: 1'b1, err: 1'b0});
    send_frame(8'h3C, 1'b1, 1'b1, "pre_en");
    get_result(e, ok);
    total++; if (!ok) begin bad++; $display("FAIL pre_en timeout: busy=%b done=%b", bus.busy, bus.done); end
    total++;
    if ({bus.data, bus.done, bus.err} !== {e.data, e.done, e.err}) begin
      bad++;
      $display("FAIL pre_en result: got data=%h done=%b err=%b want data=%h done=%b err=%b",
               bus.data, bus.done, bus.err, e.data, e.done, e.err);
    end
    last_good = 8'h3C;
    // Receiver disabled: the frame is ignored entirely.
    bus.rx_en = 1'b0;
    #(BIT_NS);
    send_frame(8'h81, 1'b1, 1'b0, "disabled");
    #(BIT_NS);
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {last_good, 3'b100}) begin
      bad++;
      $display("FAIL disabled result: got data=%h done=%b err=%b busy=%b want data=%h done=1 err=0 busy=0",
               bus.data, bus.done, bus.err, bus.busy, last_good);
    end
    // Enabled at the start edge, disabled in data bit 1.
    bus.rx_en = 1'b1;
    bus.rx = 1'b0; #(BIT_NS);
    bus.rx = 1'b1; #(BIT_NS);
    bus.rx = 1'b0; #(BIT_NS / 2);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort pre busy: got %b want 1", bus.busy); end
    bus.rx_en = 1'b0;
    #20;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", bus.busy); end
    #(BIT_NS / 2 - 20);
    for (int i = 0; i < 6; i++) begin
      bus.rx = i[0];
      #(BIT_NS);
    end
    bus.rx = 1'b1;
    #(2 * BIT_NS);
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {last_good, 3'b000}) begin
      bad++;
      $display("FAIL abort result: got data=%h done=%b err=%b busy=%b want data=%h done=0 err=0 busy=0",
               bus.data, bus.done, bus.err, bus.busy, last_good);
    end
    bus.rx_en = 1'b1;
    #(BIT_NS);
  endtask

  task automatic test_reset_mid_frame();
    exp_t e; logic ok;
    logic [7:0] d;
    d = 8'hA5;
    bus.rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      #(BIT_NS);
    end
    bus.rx = d[4];
    #(BIT_NS / 2);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst pre busy: got %b want 1", bus.busy); end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== 11'b0) begin
      bad++;
      $display("FAIL midrst outputs: got data=%h done=%b err=%b busy=%b want all 0",
               bus.data, bus.done, bus.err, bus.busy);
    end
    bus.rx = 1'b1;
    #(BIT_NS - 1);
    rst = 1'b1;
    last_good = 8'h00;
    #(BIT_NS);
    sb_q.push_back('{data: 8'hC3, done: 1'b1, err: 1'b0});
    send_frame(8'hC3, 1'b1, 1'b1, "post_rst");
    get_result(e, ok);
    total++; if (!ok) begin bad++; $display("FAIL post_rst timeout: busy=%b done=%b", bus.busy, bus.done); end
    total++;
    if ({bus.data, bus.done, bus.err, bus.busy} !== {e.data, e.done, e.err, 1'b0}) begin
      bad++;
      $display("FAIL post_rst result: got data=%h done=%b err=%b busy=%b want data=%h done=%b err=%b busy=0",
               bus.data, bus.done, bus.err, bus.busy, e.data, e.done, e.err);
    end
  endtask

  initial begin
    bus.rx    = 1'b1;
    bus.rx_en = 1'b0;
    rst       = 1'b0;
    test_reset();
    test_good_frames();
    test_framing_error();
    test_glitch();
    test_enable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
